// File: rtl/subtractor_serial_if.sv
// Handshake and operand/result bundle for the bit-serial subtractor.
// The controller drives start/a/b and the subtractor returns status and results.
interface subtractor_serial_if #(
    parameter int WIDTH = 4
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             borrow;
    logic             zero;

    modport master (
        output start, a, b,
        input  busy, done, diff, borrow, zero
    );

    modport slave (
        input  start, a, b,
        output busy, done, diff, borrow, zero
    );
endinterface

// File: rtl/subtractor_serial.sv
// Bit-serial unsigned subtractor: diff = a - b, one bit per clock, LSB first.
// A single borrow flop ripples between bits; results hold until the next completion.
module subtractor_serial #(
    parameter int WIDTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    subtractor_serial_if.slave bus
);
    localparam int              CW   = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sa_q, sa_d;
    logic [WIDTH-1:0] sb_q, sb_d;
    logic [WIDTH-1:0] sr_q, sr_d;
    logic             br_q, br_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             borrow_q, borrow_d;
    logic             zero_q, zero_d;

    logic             bit_d;
    logic             br_next;
    logic [WIDTH-1:0] sr_shift;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            sa_q     <= '0;
            sb_q     <= '0;
            sr_q     <= '0;
            br_q     <= 1'b0;
            cnt_q    <= '0;
            done_q   <= 1'b0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
            zero_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            sa_q     <= sa_d;
            sb_q     <= sb_d;
            sr_q     <= sr_d;
            br_q     <= br_d;
            cnt_q    <= cnt_d;
            done_q   <= done_d;
            diff_q   <= diff_d;
            borrow_q <= borrow_d;
            zero_q   <= zero_d;
        end
    end

    // Full-subtractor cell for the current LSB; the new bit enters sr at the MSB.
    assign bit_d    = sa_q[0] ^ sb_q[0] ^ br_q;
    assign br_next  = (~sa_q[0] & sb_q[0]) | (~(sa_q[0] ^ sb_q[0]) & br_q);
    assign sr_shift = {bit_d, sr_q[WIDTH-1:1]};

    always_comb begin
        state_d  = state_q;
        sa_d     = sa_q;
        sb_d     = sb_q;
        sr_d     = sr_q;
        br_d     = br_q;
        cnt_d    = cnt_q;
        done_d   = 1'b0;
        diff_d   = diff_q;
        borrow_d = borrow_q;
        zero_d   = zero_q;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    sa_d    = bus.a;
                    sb_d    = bus.b;
                    br_d    = 1'b0;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                sa_d  = sa_q >> 1;
                sb_d  = sb_q >> 1;
                sr_d  = sr_shift;
                br_d  = br_next;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    diff_d   = sr_shift;
                    borrow_d = br_next;
                    zero_d   = (sr_shift == '0);
                    done_d   = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.busy   = (state_q == RUN);
    assign bus.done   = done_q;
    assign bus.diff   = diff_q;
    assign bus.borrow = borrow_q;
    assign bus.zero   = zero_q;
endmodule

// File: tb/tb_subtractor_serial.sv
// Directed and exhaustive checks for the 4-bit serial subtractor.
// Outputs are sampled 1 time unit after each rising edge.
module tb_subtractor_serial;
    localparam int WIDTH = 4;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;

    subtractor_serial_if #(.WIDTH(WIDTH)) bus ();

    subtractor_serial #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Launches one operation from IDLE and checks latency, busy width, results and done width.
    task automatic run_op(input logic [3:0] a, input logic [3:0] b,
                          input logic [3:0] e_diff, input logic e_borrow, input logic e_zero);
        int lat;
        int busy_cnt;
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = a;
        bus.b     = b;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        lat       = 0;
        busy_cnt  = (bus.busy === 1'b1) ? 1 : 0;
        while (bus.done !== 1'b1 && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
            if (bus.done !== 1'b1 && bus.busy === 1'b1) busy_cnt++;
        end
        $display("op a=%0d b=%0d -> diff=%0d borrow=%0d zero=%0d latency=%0d",
                 a, b, bus.diff, bus.borrow, bus.zero, lat);
        chk("latency", lat, WIDTH);
        chk("busy_width", busy_cnt, WIDTH);
        chk("diff", bus.diff, e_diff);
        chk("borrow", bus.borrow, e_borrow);
        chk("zero", bus.zero, e_zero);
        chk("busy_at_done", bus.busy, 0);
        @(posedge clk);
        #1;
        chk("done_width", bus.done, 0);
    endtask

    initial begin
        int lat;
        int done_seen;
        logic [3:0] ed;
        n_cmp     = 0;
        n_err     = 0;
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_diff", bus.diff, 0);
        chk("rst_borrow", bus.borrow, 0);
        chk("rst_zero", bus.zero, 0);
        @(negedge clk);
        rst = 1'b0;

        // Basic, borrow and zero cases
        run_op(4'd5, 4'd3, 4'd2, 1'b0, 1'b0);
        run_op(4'd3, 4'd5, 4'd14, 1'b1, 1'b0);
        run_op(4'd0, 4'd1, 4'd15, 1'b1, 1'b0);
        run_op(4'd15, 4'd15, 4'd0, 1'b0, 1'b1);
        run_op(4'd0, 4'd0, 4'd0, 1'b0, 1'b1);

        // Start while busy is ignored; start in the done cycle is accepted
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = 4'd10;
        bus.b     = 4'd5;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        bus.start = 1'b1;
        bus.a     = 4'd1;
        bus.b     = 4'd9;
        lat = 2;
        while (bus.done !== 1'b1 && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        $display("op a=10 b=5 (start held while busy) -> diff=%0d borrow=%0d latency=%0d",
                 bus.diff, bus.borrow, lat);
        chk("ign_latency", lat, WIDTH);
        chk("ign_diff", bus.diff, 5);
        chk("ign_borrow", bus.borrow, 0);
        bus.a = 4'd8;
        bus.b = 4'd7;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        chk("b2b_busy", bus.busy, 1);
        chk("b2b_done_low", bus.done, 0);
        chk("b2b_hold_diff", bus.diff, 5);
        repeat (3) @(posedge clk);
        #1;
        chk("b2b_not_yet", bus.done, 0);
        @(posedge clk);
        #1;
        $display("op a=8 b=7 (back-to-back) -> diff=%0d borrow=%0d done=%0d",
                 bus.diff, bus.borrow, bus.done);
        chk("b2b_done", bus.done, 1);
        chk("b2b_diff", bus.diff, 1);
        chk("b2b_borrow", bus.borrow, 0);
        @(posedge clk);
        #1;
        chk("b2b_done_width", bus.done, 0);

        // Asynchronous reset mid-operation
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = 4'd12;
        bus.b     = 4'd4;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        $display("async reset mid-op -> busy=%0d done=%0d diff=%0d", bus.busy, bus.done, bus.diff);
        chk("arst_busy", bus.busy, 0);
        chk("arst_done", bus.done, 0);
        chk("arst_diff", bus.diff, 0);
        chk("arst_borrow", bus.borrow, 0);
        chk("arst_zero", bus.zero, 0);
        @(negedge clk);
        rst = 1'b0;
        done_seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            if (bus.done === 1'b1 || bus.busy === 1'b1) done_seen++;
        end
        chk("arst_no_done", done_seen, 0);
        run_op(4'd7, 4'd7, 4'd0, 1'b0, 1'b1);

        // Exhaustive sweep
        for (int i = 0; i < 16; i++) begin
            for (int j = 0; j < 16; j++) begin
                ed = 4'(i - j);
                run_op(4'(i), 4'(j), ed, (i < j), (ed == 4'd0));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
